decode_stage: RTL and testbench
===============================

Name: decode_stage

Overview:
- Pipelined instruction-decode stage for the 16-bit ISA: opcode [15:11], rs [10:8], rt [7:5], rd [4:2].
- Decodes control and immediates, reads a parametrised register file with write-back bypass, and detects load-use hazards.
- Registers all results into an ID/EX pipeline register with valid/stall/flush handling.
- Sits between fetch and execute; replaces the single-cycle combinational decode.

Parameters:
- DATA_W, 16, register/immediate/PC datapath width (>=16).
- NREG, 8, number of architectural registers (power of 2, >=8); REG_AW = clog2(NREG).
- LINK_REG, 7, register index written by link (jump-and-link) instructions.
- BYPASS, 1, 1 = same-cycle write-back data forwarded to reads; 0 = read returns old value.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- if_valid  in  1  fetch presents a valid instruction.
- if_instr  in  16  instruction word.
- if_pc  in  DATA_W  PC of if_instr.
- ex_stall  in  1  execute cannot accept; hold ID/EX.
- flush  in  1  squash instruction in decode and ID/EX (branch redirect).
- wb_en  in  1  register write enable from write-back.
- wb_reg  in  REG_AW  write-back destination.
- wb_data  in  DATA_W  write-back data.
- id_stall  out  1  to fetch: hold if_instr/if_pc this cycle (combinational).
- id_valid  out  1  ID/EX holds a valid instruction.
- id_rdata1, id_rdata2  out  DATA_W  rs/rt operand values.
- id_imm  out  DATA_W  extended immediate.
- id_wreg  out  REG_AW  destination register.
- id_regwrite  out  1  destination is written.
- id_link  out  1  destination is LINK_REG, write value is PC+2.
- id_pc  out  DATA_W  PC of the decoded instruction.
- id_jump, id_jumpreg, id_branch, id_memread, id_memwrite, id_memtoreg, id_alusrc  out  1 each  control.
- id_aluop  out  4  ALU operation.
- err  out  1  sticky decode error.

Behaviour:
- Reset (rst=0, async): every output 0; register file cleared to 0; err cleared.
- Latency: instruction accepted at edge N appears on id_* after edge N (one cycle).
- Destination register: I-format = instr[7:5]; R-format = instr[4:2]; link = LINK_REG.
- Index width: register indices are zero-extended to REG_AW; instructions address only registers 0-7.
- Immediates:
  - J-format: sign-extend instr[10:0] to DATA_W.
  - I1: instr[4:0], zero- or sign-extended per the control toExt bit.
  - I2: sign-extend instr[7:0].
- Illegal opcode or illegal mux select: err set and held until reset; the instruction still flows, with id_regwrite=0 and id_memwrite=0.
- Load-use hazard: id_valid & id_memread & id_regwrite & ID/EX dest equals a source the current instr actually uses (rs and/or rt per format), with if_valid=1.
  - id_stall=1.
  - Next edge loads a bubble (id_valid=0), or holds ID/EX if ex_stall.
  - The decode instruction is retried.
- ex_stall=1: ID/EX holds all values; id_stall=1.
- Priority at each edge: flush > ex_stall > hazard > normal load.
- flush=1: id_valid<=0 at the next edge regardless of the other inputs; id_stall=0.
- Normal load: if_valid=0 loads a bubble (id_valid=0, other id_* don't-care but held at previous values).
- Register file:
  - Write on a rising edge when wb_en=1.
  - Reads are asynchronous.
  - BYPASS=1: a read of wb_reg while wb_en=1 returns wb_data in the same cycle.
- Register 0 is an ordinary register (no hardwired zero).
- Operand hold: operands are captured at the ID/EX load. A write-back during a hold does not update held id_rdata*; the stall retry re-reads.

Decomposition:
- Shared package: opcode constants, regDst encodings (REG_I_FORMAT, REG_R_FORMAT, REG_R7), immediate selects (IMM_J, IMM_I1, IMM_I2), ALUOp encodings. This extends the existing control_config definitions.
- Reuse the existing control decoder unchanged.
- One new sub-module, regfile_bypass_p: parametrised by DATA_W, NREG and BYPASS; two read ports and one write port; async active-low reset.

Test Plan:
- Reset then ADDI r2,r1,#-3 with r1=0x0005 -> after one cycle id_valid=1, id_rdata1=0x0005, id_imm=0xFFFD, id_wreg=2.
- wb_en=1, wb_reg=3, wb_data=0xBEEF in the same cycle an R-format reads r3 (BYPASS=1) -> id_rdata1=0xBEEF; with BYPASS=0 -> previous r3 value.
- LD r4 in ID/EX, then an ADD using r4 as rs -> id_stall=1 for exactly one cycle, one bubble (id_valid=0), then the ADD issues with id_valid=1.
- ex_stall held 3 cycles with a valid instr in ID/EX -> id_* unchanged for 3 cycles, id_stall=1 throughout.
- flush asserted together with a hazard and ex_stall -> next edge id_valid=0, id_stall=0.
- Jump-and-link with instr[10:0]=0x7FF at pc=0x0010 -> id_imm=0xFFFF, id_wreg=7, id_link=1, id_pc=0x0010.
- Illegal opcode -> err=1 and held; id_regwrite=0; err cleared only by rst=0.

Source files
------------

// File: rtl/decode_stage_pkg.sv
// Shared decode definitions for the 16-bit ISA: opcodes, mux selects, ALU ops
// and the control decoder that maps an opcode to its control word.
package decode_stage_pkg;

  localparam int unsigned INSTR_W = 16;
  localparam int unsigned OPC_W   = 5;
  localparam int unsigned ALUOP_W = 4;

  localparam logic [OPC_W-1:0] OP_ADD  = 5'd0;
  localparam logic [OPC_W-1:0] OP_SUB  = 5'd1;
  localparam logic [OPC_W-1:0] OP_AND  = 5'd2;
  localparam logic [OPC_W-1:0] OP_OR   = 5'd3;
  localparam logic [OPC_W-1:0] OP_XOR  = 5'd4;
  localparam logic [OPC_W-1:0] OP_SLT  = 5'd5;
  localparam logic [OPC_W-1:0] OP_ADDI = 5'd8;
  localparam logic [OPC_W-1:0] OP_ANDI = 5'd9;
  localparam logic [OPC_W-1:0] OP_ORI  = 5'd10;
  localparam logic [OPC_W-1:0] OP_LD   = 5'd12;
  localparam logic [OPC_W-1:0] OP_ST   = 5'd13;
  localparam logic [OPC_W-1:0] OP_BEQ  = 5'd14;
  localparam logic [OPC_W-1:0] OP_BRZ  = 5'd18;
  localparam logic [OPC_W-1:0] OP_J    = 5'd24;
  localparam logic [OPC_W-1:0] OP_JAL  = 5'd25;
  localparam logic [OPC_W-1:0] OP_JR   = 5'd26;
  localparam logic [OPC_W-1:0] OP_NOP  = 5'd31;

  typedef enum logic [1:0] {
    REG_I_FORMAT = 2'd0,
    REG_R_FORMAT = 2'd1,
    REG_R7       = 2'd2
  } regdst_e;

  typedef enum logic [1:0] {
    IMM_J  = 2'd0,
    IMM_I1 = 2'd1,
    IMM_I2 = 2'd2
  } immsel_e;

  typedef enum logic [ALUOP_W-1:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_OR  = 4'd3,
    ALU_XOR = 4'd4,
    ALU_SLT = 4'd5
  } aluop_e;

  typedef struct packed {
    logic    legal;
    logic    uses_rs;
    logic    uses_rt;
    regdst_e regdst;
    immsel_e immsel;
    logic    toext;
    logic    regwrite;
    logic    link;
    logic    jump;
    logic    jumpreg;
    logic    branch;
    logic    memread;
    logic    memwrite;
    logic    memtoreg;
    logic    alusrc;
    aluop_e  aluop;
  } ctrl_t;

  // Opcode to control word; unknown opcodes come back with legal=0 and no side effects
  function automatic ctrl_t control_decode(input logic [OPC_W-1:0] opc);
    ctrl_t c;
    c        = '0;
    c.legal  = 1'b1;
    c.regdst = REG_I_FORMAT;
    c.immsel = IMM_I1;
    c.aluop  = ALU_ADD;
    case (opc)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLT: begin
        c.regdst   = REG_R_FORMAT;
        c.regwrite = 1'b1;
        c.uses_rs  = 1'b1;
        c.uses_rt  = 1'b1;
        case (opc)
          OP_SUB:  c.aluop = ALU_SUB;
          OP_AND:  c.aluop = ALU_AND;
          OP_OR:   c.aluop = ALU_OR;
          OP_XOR:  c.aluop = ALU_XOR;
          OP_SLT:  c.aluop = ALU_SLT;
          default: c.aluop = ALU_ADD;
        endcase
      end
      OP_ADDI, OP_ANDI, OP_ORI: begin
        c.regwrite = 1'b1;
        c.alusrc   = 1'b1;
        c.uses_rs  = 1'b1;
        c.toext    = (opc == OP_ADDI);
        c.aluop    = (opc == OP_ANDI) ? ALU_AND : (opc == OP_ORI) ? ALU_OR : ALU_ADD;
      end
      OP_LD: begin
        c.regwrite = 1'b1;
        c.memread  = 1'b1;
        c.memtoreg = 1'b1;
        c.alusrc   = 1'b1;
        c.uses_rs  = 1'b1;
        c.toext    = 1'b1;
      end
      OP_ST: begin
        c.memwrite = 1'b1;
        c.alusrc   = 1'b1;
        c.uses_rs  = 1'b1;
        c.uses_rt  = 1'b1;
        c.toext    = 1'b1;
      end
      OP_BEQ: begin
        c.branch  = 1'b1;
        c.uses_rs = 1'b1;
        c.uses_rt = 1'b1;
        c.toext   = 1'b1;
        c.aluop   = ALU_SUB;
      end
      OP_BRZ: begin
        c.branch  = 1'b1;
        c.uses_rs = 1'b1;
        c.immsel  = IMM_I2;
        c.aluop   = ALU_SUB;
      end
      OP_J: begin
        c.jump   = 1'b1;
        c.immsel = IMM_J;
      end
      OP_JAL: begin
        c.jump     = 1'b1;
        c.link     = 1'b1;
        c.regwrite = 1'b1;
        c.regdst   = REG_R7;
        c.immsel   = IMM_J;
      end
      OP_JR: begin
        c.jumpreg = 1'b1;
        c.uses_rs = 1'b1;
      end
      OP_NOP: ;
      default: c.legal = 1'b0;
    endcase
    return c;
  endfunction

  // Guards against mux selects outside the defined encodings
  function automatic logic sel_legal(input ctrl_t c);
    return (c.regdst inside {REG_I_FORMAT, REG_R_FORMAT, REG_R7}) &&
           (c.immsel inside {IMM_J, IMM_I1, IMM_I2});
  endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Fetch-to-decode handshake and ID/EX pipeline bus. master = decode stage.
interface decode_stage_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned NREG   = 8
);
  localparam int unsigned REG_AW = $clog2(NREG);

  logic                                if_valid;
  logic [decode_stage_pkg::INSTR_W-1:0] if_instr;
  logic [DATA_W-1:0]                   if_pc;
  logic                                id_stall;

  logic                                id_valid;
  logic [DATA_W-1:0]                   id_rdata1;
  logic [DATA_W-1:0]                   id_rdata2;
  logic [DATA_W-1:0]                   id_imm;
  logic [REG_AW-1:0]                   id_wreg;
  logic                                id_regwrite;
  logic                                id_link;
  logic [DATA_W-1:0]                   id_pc;
  logic                                id_jump;
  logic                                id_jumpreg;
  logic                                id_branch;
  logic                                id_memread;
  logic                                id_memwrite;
  logic                                id_memtoreg;
  logic                                id_alusrc;
  logic [decode_stage_pkg::ALUOP_W-1:0] id_aluop;

  modport master (
    input  if_valid, if_instr, if_pc,
    output id_stall, id_valid, id_rdata1, id_rdata2, id_imm, id_wreg, id_regwrite,
           id_link, id_pc, id_jump, id_jumpreg, id_branch, id_memread, id_memwrite,
           id_memtoreg, id_alusrc, id_aluop
  );

  modport slave (
    output if_valid, if_instr, if_pc,
    input  id_stall, id_valid, id_rdata1, id_rdata2, id_imm, id_wreg, id_regwrite,
           id_link, id_pc, id_jump, id_jumpreg, id_branch, id_memread, id_memwrite,
           id_memtoreg, id_alusrc, id_aluop
  );
endinterface

// File: rtl/decode_stage_regfile_bypass_p.sv
// Register file: two async read ports, one write port, optional same-cycle
// write-back forwarding onto the read ports.
module regfile_bypass_p #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned NREG   = 8,
  parameter int unsigned BYPASS = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we,
  input  logic [$clog2(NREG)-1:0]  waddr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic [$clog2(NREG)-1:0]  raddr1,
  input  logic [$clog2(NREG)-1:0]  raddr2,
  output logic [DATA_W-1:0]        rdata1_c,
  output logic [DATA_W-1:0]        rdata2_c
);

  logic [DATA_W-1:0] mem [NREG];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(NREG); i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  generate
    if (BYPASS != 0) begin : g_bypass
      assign rdata1_c = (we && (waddr == raddr1)) ? wdata : mem[raddr1];
      assign rdata2_c = (we && (waddr == raddr2)) ? wdata : mem[raddr2];
    end else begin : g_no_bypass
      assign rdata1_c = mem[raddr1];
      assign rdata2_c = mem[raddr2];
    end
  endgenerate

endmodule

// File: rtl/decode_stage.sv
// Pipelined decode: control/immediate decode, register read with write-back
// bypass, load-use hazard detection and the ID/EX pipeline register.
module decode_stage
  import decode_stage_pkg::*;
#(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned NREG     = 8,
  parameter int unsigned LINK_REG = 7,
  parameter int unsigned BYPASS   = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  decode_stage_if.master          bus,
  input  logic                    ex_stall,
  input  logic                    flush,
  input  logic                    wb_en,
  input  logic [$clog2(NREG)-1:0] wb_reg,
  input  logic [DATA_W-1:0]       wb_data,
  output logic                    err
);

  localparam int unsigned REG_AW = $clog2(NREG);

  logic [INSTR_W-1:0] instr_c;
  ctrl_t              ctrl_c;
  logic [REG_AW-1:0]  rs_c, rt_c, rd_c, wreg_c;
  logic [DATA_W-1:0]  imm_c, rdata1_c, rdata2_c;
  logic               legal_c, hazard_c, load_c;

  assign instr_c = bus.if_instr;
  assign ctrl_c  = control_decode(instr_c[15:11]);
  assign rs_c    = REG_AW'(instr_c[10:8]);
  assign rt_c    = REG_AW'(instr_c[7:5]);
  assign rd_c    = REG_AW'(instr_c[4:2]);
  assign legal_c = ctrl_c.legal & sel_legal(ctrl_c);

  always_comb begin
    wreg_c = rt_c;
    case (ctrl_c.regdst)
      REG_I_FORMAT: wreg_c = rt_c;
      REG_R_FORMAT: wreg_c = rd_c;
      REG_R7:       wreg_c = REG_AW'(LINK_REG);
      default:      wreg_c = rt_c;
    endcase
  end

  always_comb begin
    imm_c = '0;
    case (ctrl_c.immsel)
      IMM_J:   imm_c = {{(DATA_W-11){instr_c[10]}}, instr_c[10:0]};
      IMM_I1:  imm_c = {{(DATA_W-5){ctrl_c.toext & instr_c[4]}}, instr_c[4:0]};
      IMM_I2:  imm_c = {{(DATA_W-8){instr_c[7]}}, instr_c[7:0]};
      default: imm_c = '0;
    endcase
  end

  regfile_bypass_p #(
    .DATA_W (DATA_W),
    .NREG   (NREG),
    .BYPASS (BYPASS)
  ) u_rf (
    .clk      (clk),
    .rst      (rst),
    .we       (wb_en),
    .waddr    (wb_reg),
    .wdata    (wb_data),
    .raddr1   (rs_c),
    .raddr2   (rt_c),
    .rdata1_c (rdata1_c),
    .rdata2_c (rdata2_c)
  );

  // Load in ID/EX whose destination feeds a source this instruction really reads
  assign hazard_c = bus.id_valid & bus.id_memread & bus.id_regwrite & bus.if_valid &
                    ((ctrl_c.uses_rs & (rs_c == bus.id_wreg)) |
                     (ctrl_c.uses_rt & (rt_c == bus.id_wreg)));

  assign bus.id_stall = rst & ~flush & (ex_stall | hazard_c);
  assign load_c       = ~flush & ~ex_stall & ~hazard_c & bus.if_valid;

  // ID/EX register: flush > ex_stall > hazard > normal load
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.id_valid    <= 1'b0;
      bus.id_rdata1   <= '0;
      bus.id_rdata2   <= '0;
      bus.id_imm      <= '0;
      bus.id_wreg     <= '0;
      bus.id_regwrite <= 1'b0;
      bus.id_link     <= 1'b0;
      bus.id_pc       <= '0;
      bus.id_jump     <= 1'b0;
      bus.id_jumpreg  <= 1'b0;
      bus.id_branch   <= 1'b0;
      bus.id_memread  <= 1'b0;
      bus.id_memwrite <= 1'b0;
      bus.id_memtoreg <= 1'b0;
      bus.id_alusrc   <= 1'b0;
      bus.id_aluop    <= '0;
      err             <= 1'b0;
    end else begin
      if (flush || (!ex_stall && hazard_c)) begin
        bus.id_valid <= 1'b0;
      end else if (!ex_stall) begin
        bus.id_valid <= bus.if_valid;
      end
      if (load_c) begin
        bus.id_rdata1   <= rdata1_c;
        bus.id_rdata2   <= rdata2_c;
        bus.id_imm      <= imm_c;
        bus.id_wreg     <= wreg_c;
        bus.id_regwrite <= ctrl_c.regwrite & legal_c;
        bus.id_link     <= ctrl_c.link;
        bus.id_pc       <= bus.if_pc;
        bus.id_jump     <= ctrl_c.jump;
        bus.id_jumpreg  <= ctrl_c.jumpreg;
        bus.id_branch   <= ctrl_c.branch;
        bus.id_memread  <= ctrl_c.memread;
        bus.id_memwrite <= ctrl_c.memwrite & legal_c;
        bus.id_memtoreg <= ctrl_c.memtoreg;
        bus.id_alusrc   <= ctrl_c.alusrc;
        bus.id_aluop    <= ctrl_c.aluop;
        if (!legal_c) err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: directed scenarios plus random traffic
// against an ISA-level reference model; BYPASS=1 and BYPASS=0 instances in parallel.
module tb_decode_stage;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        ex_stall, flush, wb_en;
  logic [2:0]  wb_reg;
  logic [15:0] wb_data;
  logic        err, err0;

  decode_stage_if #(.DATA_W(16), .NREG(8)) bus ();
  decode_stage_if #(.DATA_W(16), .NREG(8)) bus0 ();

  assign bus0.if_valid = bus.if_valid;
  assign bus0.if_instr = bus.if_instr;
  assign bus0.if_pc    = bus.if_pc;

  decode_stage #(.DATA_W(16), .NREG(8), .LINK_REG(7), .BYPASS(1)) dut (
    .clk(clk), .rst(rst), .bus(bus), .ex_stall(ex_stall), .flush(flush),
    .wb_en(wb_en), .wb_reg(wb_reg), .wb_data(wb_data), .err(err)
  );

  decode_stage #(.DATA_W(16), .NREG(8), .LINK_REG(7), .BYPASS(0)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0), .ex_stall(ex_stall), .flush(flush),
    .wb_en(wb_en), .wb_reg(wb_reg), .wb_data(wb_data), .err(err0)
  );

  typedef struct {
    bit          valid, legal, err, use_rs, use_rt, chk_imm;
    logic [15:0] rd1, rd2, rd1nb, rd2nb, imm, pc;
    logic [2:0]  wreg;
    bit          regwrite, link, jump, jumpreg, branch, memread, memwrite, memtoreg, alusrc;
    logic [3:0]  aluop;
  } exp_t;

  logic [15:0] rf [8];
  exp_t        m;
  bit          m_err;
  exp_t        q[$];
  int          n_assert = 0;
  int          n_fail = 0;
  bit          active = 1'b0;
  bit          last_stall = 1'b0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // ISA-level meaning of one instruction word, operands read as seen this cycle
  function automatic exp_t mdec(input logic [15:0] ins, input logic [15:0] pc);
    exp_t e;
    logic [4:0] op;
    logic [2:0] rs, rt;
    e = '{default: '0};
    op = ins[15:11];
    rs = ins[10:8];
    rt = ins[7:5];
    e.valid = 1; e.legal = 1; e.chk_imm = 1; e.pc = pc;
    e.rd1   = (wb_en && wb_reg == rs) ? wb_data : rf[rs];
    e.rd2   = (wb_en && wb_reg == rt) ? wb_data : rf[rt];
    e.rd1nb = rf[rs];
    e.rd2nb = rf[rt];
    case (op)
      5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5: begin
        e.wreg = ins[4:2]; e.regwrite = 1; e.aluop = 4'(op);
        e.use_rs = 1; e.use_rt = 1; e.chk_imm = 0;
      end
      5'd8, 5'd9, 5'd10: begin
        e.wreg = rt; e.regwrite = 1; e.alusrc = 1; e.use_rs = 1;
        e.imm = (op == 5'd8) ? 16'($signed(ins[4:0])) : 16'(ins[4:0]);
        e.aluop = (op == 5'd9) ? 4'd2 : (op == 5'd10) ? 4'd3 : 4'd0;
      end
      5'd12: begin
        e.wreg = rt; e.regwrite = 1; e.memread = 1; e.memtoreg = 1; e.alusrc = 1;
        e.use_rs = 1; e.imm = 16'($signed(ins[4:0]));
      end
      5'd13: begin
        e.memwrite = 1; e.alusrc = 1; e.use_rs = 1; e.use_rt = 1;
        e.imm = 16'($signed(ins[4:0]));
      end
      5'd14: begin
        e.branch = 1; e.aluop = 4'd1; e.use_rs = 1; e.use_rt = 1;
        e.imm = 16'($signed(ins[4:0]));
      end
      5'd18: begin
        e.branch = 1; e.aluop = 4'd1; e.use_rs = 1; e.imm = 16'($signed(ins[7:0]));
      end
      5'd24: begin
        e.jump = 1; e.imm = 16'($signed(ins[10:0]));
      end
      5'd25: begin
        e.jump = 1; e.link = 1; e.regwrite = 1; e.wreg = 3'd7;
        e.imm = 16'($signed(ins[10:0]));
      end
      5'd26: begin
        e.jumpreg = 1; e.use_rs = 1; e.chk_imm = 0;
      end
      5'd31: e.chk_imm = 0;
      default: begin
        e.legal = 0; e.chk_imm = 0;
      end
    endcase
    return e;
  endfunction

  // Drive one cycle, check the combinational stall, advance the model, push expectation
  task automatic step(input logic v, input logic [15:0] ins, input logic [15:0] pc,
                      input logic xs, input logic fl, input logic we,
                      input logic [2:0] wr, input logic [15:0] wd);
    exp_t d, r;
    bit   haz, st;
    @(negedge clk);
    bus.if_valid = v; bus.if_instr = ins; bus.if_pc = pc;
    ex_stall = xs; flush = fl; wb_en = we; wb_reg = wr; wb_data = wd;
    #1;
    d   = mdec(ins, pc);
    haz = m.valid && m.memread && m.regwrite && v &&
          ((d.use_rs && ins[10:8] == m.wreg) || (d.use_rt && ins[7:5] == m.wreg));
    st  = !fl && (xs || haz);
    chk("id_stall", 32'(bus.id_stall), 32'(st));
    chk("dut0_id_stall", 32'(bus0.id_stall), 32'(st));
    last_stall = st;
    if (fl) m.valid = 0;
    else if (!xs) begin
      if (haz) m.valid = 0;
      else if (v) begin
        m = d;
        if (!d.legal) m_err = 1;
      end else m.valid = 0;
    end
    if (we) rf[wr] = wd;
    r = m;
    r.err = m_err;
    q.push_back(r);
    active = 1'b1;
  endtask

  function automatic logic [15:0] rtype(input int op, input int rs, input int rt, input int rd);
    return {5'(op), 3'(rs), 3'(rt), 3'(rd), 2'b00};
  endfunction

  function automatic logic [15:0] itype(input int op, input int rs, input int rt, input int imm);
    return {5'(op), 3'(rs), 3'(rt), 5'(imm)};
  endfunction

  // Monitor: pop one expectation per cycle and compare what the DUTs present
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (active) begin
        if (q.size() == 0) chk("queue_underflow", 32'd1, 32'd0);
        else begin
          e = q.pop_front();
          chk("id_valid", 32'(bus.id_valid), 32'(e.valid));
          chk("dut0_id_valid", 32'(bus0.id_valid), 32'(e.valid));
          chk("err", 32'(err), 32'(e.err));
          chk("dut0_err", 32'(err0), 32'(e.err));
          if (e.valid) begin
            chk("id_pc", 32'(bus.id_pc), 32'(e.pc));
            chk("id_regwrite", 32'(bus.id_regwrite), 32'(e.regwrite));
            chk("id_memwrite", 32'(bus.id_memwrite), 32'(e.memwrite));
            if (e.legal) begin
              chk("id_rdata1", 32'(bus.id_rdata1), 32'(e.rd1));
              chk("id_rdata2", 32'(bus.id_rdata2), 32'(e.rd2));
              chk("dut0_id_rdata1", 32'(bus0.id_rdata1), 32'(e.rd1nb));
              chk("dut0_id_rdata2", 32'(bus0.id_rdata2), 32'(e.rd2nb));
              chk("ctrl", 32'({bus.id_link, bus.id_jump, bus.id_jumpreg, bus.id_branch,
                               bus.id_memread, bus.id_memtoreg, bus.id_alusrc}),
                  32'({e.link, e.jump, e.jumpreg, e.branch, e.memread, e.memtoreg, e.alusrc}));
              chk("id_aluop", 32'(bus.id_aluop), 32'(e.aluop));
              if (e.regwrite) chk("id_wreg", 32'(bus.id_wreg), 32'(e.wreg));
              if (e.chk_imm) chk("id_imm", 32'(bus.id_imm), 32'(e.imm));
            end
          end
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0]  legal_ops [17] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd8, 5'd9, 5'd10,
                                    5'd12, 5'd13, 5'd14, 5'd18, 5'd24, 5'd25, 5'd26, 5'd31};
    logic [15:0] ins;
    logic [4:0]  op;
    m = '{default: '0};
    m_err = 0;
    for (int i = 0; i < 8; i++) rf[i] = '0;
    bus.if_valid = 1; bus.if_instr = itype(12, 0, 4, 0); bus.if_pc = 16'h1234;
    ex_stall = 1; flush = 0; wb_en = 0; wb_reg = 0; wb_data = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_id_valid", 32'(bus.id_valid), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_id_stall", 32'(bus.id_stall), 32'd0);
    chk("rst_id_pc", 32'(bus.id_pc), 32'd0);
    chk("rst_id_rdata1", 32'(bus.id_rdata1), 32'd0);
    rst = 1; ex_stall = 0; bus.if_valid = 0;

    // r1=5, then ADDI r2,r1,#-3
    step(0, 16'h0, 16'h0, 0, 0, 1, 3'd1, 16'h0005);
    step(1, itype(8, 1, 2, 5'h1D), 16'h0100, 0, 0, 0, 3'd0, 16'h0);
    // r3=0x1111, then ADD reading r3 while write-back of 0xBEEF to r3
    step(0, 16'h0, 16'h0, 0, 0, 1, 3'd3, 16'h1111);
    step(1, rtype(0, 3, 0, 4), 16'h0102, 0, 0, 1, 3'd3, 16'hBEEF);
    // load-use: LD r4, then ADD r5,r4,r1 (retried after the bubble)
    step(1, itype(12, 0, 4, 2), 16'h0104, 0, 0, 0, 3'd0, 16'h0);
    step(1, rtype(0, 4, 1, 5), 16'h0106, 0, 0, 0, 3'd0, 16'h0);
    step(1, rtype(0, 4, 1, 5), 16'h0106, 0, 0, 0, 3'd0, 16'h0);
    // ex_stall for three cycles with write-back to the held source
    step(1, itype(9, 2, 6, 5'h1F), 16'h0108, 0, 0, 0, 3'd0, 16'h0);
    for (int i = 0; i < 3; i++) step(1, rtype(1, 6, 2, 3), 16'h010A, 1, 0, 1, 3'd2, 16'(16'hA000 + i));
    step(1, rtype(1, 6, 2, 3), 16'h010A, 0, 0, 0, 3'd0, 16'h0);
    // flush together with a load-use hazard and ex_stall
    step(1, itype(12, 1, 4, 0), 16'h010C, 0, 0, 0, 3'd0, 16'h0);
    step(1, rtype(2, 4, 4, 1), 16'h010E, 1, 1, 0, 3'd0, 16'h0);
    // JAL with all-ones offset
    step(1, {5'd25, 11'h7FF}, 16'h0010, 0, 0, 0, 3'd0, 16'h0);

    ins = 16'h0;
    for (int i = 0; i < 400; i++) begin
      if (!last_stall) begin
        op  = ($urandom_range(0, 3) == 0) ? 5'd12 : legal_ops[$urandom_range(0, 16)];
        ins = {op, 11'($urandom)};
      end
      step(1'($urandom_range(0, 5) != 0), ins, 16'($urandom),
           1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 11) == 0),
           1'($urandom_range(0, 1)), 3'($urandom), 16'($urandom));
    end

    // illegal opcode: sticky err, writes suppressed
    step(1, {5'd6, 11'h7FF}, 16'h0200, 0, 0, 0, 3'd0, 16'h0);
    for (int i = 0; i < 3; i++) step(1, rtype(0, i, 1, 2), 16'(16'h0202 + 2 * i), 0, 0, 0, 3'd0, 16'h0);

    @(posedge clk);
    #3;
    active = 1'b0;
    chk("queue_drained", 32'(q.size()), 32'd0);
    chk("err_sticky", 32'(err), 32'd1);
    @(negedge clk);
    rst = 0;
    #1;
    chk("err_cleared_by_rst", 32'(err), 32'd0);
    chk("id_valid_after_rst", 32'(bus.id_valid), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
